// File: rtl/regread_pkg.sv
// Shared defaults and the operand bundle type for the register-read stage.
package regread_pkg;

    localparam int DEF_WIDTH     = 32;
    localparam int DEF_RSELWIDTH = 4;
    localparam int DEF_OPW       = 8;
    localparam int NREGS         = 2 ** DEF_RSELWIDTH;

    // One issued instruction as it leaves the stage toward execute.
    typedef struct packed {
        logic [DEF_OPW-1:0]       op;
        logic [DEF_WIDTH-1:0]     a;
        logic [DEF_WIDTH-1:0]     b;
        logic [DEF_WIDTH-1:0]     c;
        logic                     we;
        logic [DEF_RSELWIDTH-1:0] wsel;
    } operand_t;

endpackage

// File: rtl/regread_stage_scoreboard.sv
// Per-register busy tracking for writes in flight, with the hazard check that
// lets a same-cycle writeback release a waiting instruction.
module scoreboard
    import regread_pkg::*;
#(
    parameter int RSELWIDTH = DEF_RSELWIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 set_en,
    input  logic [RSELWIDTH-1:0] set_sel,
    input  logic                 wb_clr,
    input  logic [RSELWIDTH-1:0] wb_sel,
    input  logic                 flush_clr,
    input  logic [RSELWIDTH-1:0] flush_sel,
    input  logic [RSELWIDTH-1:0] asel,
    input  logic [RSELWIDTH-1:0] bsel,
    input  logic [RSELWIDTH-1:0] csel,
    input  logic                 we,
    input  logic [RSELWIDTH-1:0] wsel,
    output logic                 hazard
);

    localparam int NR = 2 ** RSELWIDTH;

    logic [NR-1:0] busy;
    logic [NR-1:0] busy_next;
    logic          a_raw, b_raw, c_raw, waw;

    // Clears are applied before the set so a new writer keeps its register busy.
    always_comb begin
        busy_next = busy;
        if (wb_clr)    busy_next[wb_sel]    = 1'b0;
        if (flush_clr) busy_next[flush_sel] = 1'b0;
        if (set_en)    busy_next[set_sel]   = 1'b1;
    end

    // A register being written back this cycle is no longer a hazard.
    assign a_raw  = busy[asel] && !(wb_clr && (wb_sel == asel));
    assign b_raw  = busy[bsel] && !(wb_clr && (wb_sel == bsel));
    assign c_raw  = busy[csel] && !(wb_clr && (wb_sel == csel));
    assign waw    = we && busy[wsel] && !(wb_clr && (wb_sel == wsel));
    assign hazard = a_raw || b_raw || c_raw || waw;

    // Busy vector register; reset drops all in-flight tracking at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

endmodule

// File: rtl/regread_stage.sv
// Operand-fetch stage: drives register file read selects, forwards same-cycle
// writeback data, and holds one issued instruction toward execute.
module regread_stage
    import regread_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int RSELWIDTH = DEF_RSELWIDTH,
    parameter int OPW       = DEF_OPW
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [OPW-1:0]       in_op,
    input  logic [RSELWIDTH-1:0] in_asel,
    input  logic [RSELWIDTH-1:0] in_bsel,
    input  logic [RSELWIDTH-1:0] in_csel,
    input  logic                 in_we,
    input  logic [RSELWIDTH-1:0] in_wsel,
    output logic [RSELWIDTH-1:0] asel,
    output logic [RSELWIDTH-1:0] bsel,
    output logic [RSELWIDTH-1:0] csel,
    input  logic [WIDTH-1:0]     adata,
    input  logic [WIDTH-1:0]     bdata,
    input  logic [WIDTH-1:0]     cdata,
    input  logic                 wb_we,
    input  logic [RSELWIDTH-1:0] wb_wsel,
    input  logic [WIDTH-1:0]     wb_wdata,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OPW-1:0]       out_op,
    output logic [WIDTH-1:0]     out_a,
    output logic [WIDTH-1:0]     out_b,
    output logic [WIDTH-1:0]     out_c,
    output logic                 out_we,
    output logic [RSELWIDTH-1:0] out_wsel
);

    logic             hazard;
    logic             accept;
    logic [WIDTH-1:0] fwd_a, fwd_b, fwd_c;

    assign asel = in_asel;
    assign bsel = in_bsel;
    assign csel = in_csel;

    // The register file only sees the writeback at the edge, so bypass it here.
    assign fwd_a = (wb_we && (wb_wsel == in_asel)) ? wb_wdata : adata;
    assign fwd_b = (wb_we && (wb_wsel == in_bsel)) ? wb_wdata : bdata;
    assign fwd_c = (wb_we && (wb_wsel == in_csel)) ? wb_wdata : cdata;

    assign in_ready = !flush && !hazard && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    scoreboard #(
        .RSELWIDTH(RSELWIDTH)
    ) u_sb (
        .clk       (clk),
        .rst_n     (rst_n),
        .set_en    (accept && in_we),
        .set_sel   (in_wsel),
        .wb_clr    (wb_we),
        .wb_sel    (wb_wsel),
        .flush_clr (flush && out_valid && out_we),
        .flush_sel (out_wsel),
        .asel      (in_asel),
        .bsel      (in_bsel),
        .csel      (in_csel),
        .we        (in_we),
        .wsel      (in_wsel),
        .hazard    (hazard)
    );

    // One-entry output register: load on accept, drop on drain or flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_op    <= '0;
            out_a     <= '0;
            out_b     <= '0;
            out_c     <= '0;
            out_we    <= 1'b0;
            out_wsel  <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_op    <= in_op;
            out_a     <= fwd_a;
            out_b     <= fwd_b;
            out_c     <= fwd_c;
            out_we    <= in_we;
            out_wsel  <= in_wsel;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
